// File: rtl/tx_frame_ctrl_pkg.sv
// Shared types and constants for the TX frame scheduler (tx_frame_ctrl).
// Pilot constants are only consumed when TX_FRAME_CTRL_PILOT_EN is defined.
package tx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_GAP
    } tx_frm_state_t;

    typedef enum logic [1:0] {
        SRC_PRBS     = 2'b00,
        SRC_PREAMBLE = 2'b01,
        SRC_MUTE     = 2'b10,
        SRC_PILOT    = 2'b11
    } tx_src_t;

    // Opposite constellation corners for the alternating preamble
    localparam logic [3:0]  PREAMBLE_EVEN = 4'b0000;
    localparam logic [3:0]  PREAMBLE_ODD  = 4'b1010;
    localparam int unsigned PILOT_PERIOD  = 16;
    localparam logic [3:0]  PILOT_BITS    = 4'b0000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_frame_ctrl_timer.sv
// Loadable clock down-counter; expired_o is high while the count sits at zero.
// Loading N-1 therefore yields exactly N clocks before expiry is seen.
module tx_frm_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_ctrl.sv
// TX frame scheduler: preamble -> payload -> RRC flush -> inter-frame gap.
// Define TX_FRAME_CTRL_PILOT_EN to insert a pilot after every PILOT_PERIOD data symbols.
module tx_frame_ctrl
    import tx_frame_ctrl_pkg::*;
#(
    parameter int unsigned PREAMBLE_SYMS = 32,
    parameter int unsigned LEN_W         = 12,
    parameter int unsigned FLUSH_CLKS    = 40,
    parameter int unsigned GAP_CLKS      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             abort,
    input  logic             sym_tick,
    output logic             tx_en,
    output logic [1:0]       src_sel,
    output logic [3:0]       preamble_bits,
    output logic [LEN_W-1:0] sym_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             len_err
);

    localparam int unsigned CNT_W = $clog2(max_u(FLUSH_CLKS, GAP_CLKS) + 1);

    tx_frm_state_t    state_q, state_d;
    tx_src_t          src_q, src_d;
    logic             tx_en_q, tx_en_d;
    logic [3:0]       pre_q, pre_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lerr_q, lerr_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             to_flush;
    logic [LEN_W-1:0] idx_inc;

`ifdef TX_FRAME_CTRL_PILOT_EN
    localparam int unsigned PILOT_W = $clog2(PILOT_PERIOD);
`endif

    assign idx_inc = idx_q + LEN_W'(1);

    tx_frm_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        tx_en_d  = tx_en_q;
        pre_d    = pre_q;
        idx_d    = idx_q;
        len_d    = len_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lerr_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        to_flush = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (payload_len != '0) begin
                        state_d = ST_PREAMBLE;
                        len_d   = payload_len;
                        tx_en_d = 1'b1;
                        src_d   = SRC_PREAMBLE;
                        pre_d   = PREAMBLE_EVEN;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (abort) begin
                    to_flush = 1'b1;
                end else if (sym_tick) begin
                    if (idx_q == LEN_W'(PREAMBLE_SYMS - 1)) begin
                        state_d = ST_PAYLOAD;
                        idx_d   = '0;
                        src_d   = SRC_PRBS;
                        pre_d   = PREAMBLE_EVEN;
                    end else begin
                        idx_d = idx_inc;
                        pre_d = idx_inc[0] ? PREAMBLE_ODD : PREAMBLE_EVEN;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (abort) begin
                    to_flush = 1'b1;
                end else if (sym_tick) begin
`ifdef TX_FRAME_CTRL_PILOT_EN
                    // A tick while the pilot is on air ends the pilot; it is not a data symbol
                    if (src_q == SRC_PILOT) begin
                        src_d = SRC_PRBS;
                    end else if (idx_q == len_q - LEN_W'(1)) begin
                        to_flush = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        if (idx_inc[PILOT_W-1:0] == '0) begin
                            src_d = SRC_PILOT;
                            pre_d = PILOT_BITS;
                        end
                    end
`else
                    if (idx_q == len_q - LEN_W'(1)) begin
                        to_flush = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                    end
`endif
                end
            end
            ST_FLUSH: begin
                if (tmr_expired) begin
                    state_d  = ST_GAP;
                    tx_en_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CLKS - 1);
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Terminal tick and abort share one entry path so a coincident pair enters FLUSH once
        if (to_flush) begin
            state_d  = ST_FLUSH;
            src_d    = SRC_MUTE;
            pre_d    = PREAMBLE_EVEN;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(FLUSH_CLKS - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_MUTE;
            tx_en_q <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            tx_en_q <= tx_en_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

    assign tx_en         = tx_en_q;
    assign src_sel       = src_q;
    assign preamble_bits = pre_q;
    assign sym_idx       = idx_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign len_err       = lerr_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: expected output segments (vector + hold length) are queued
// by the stimulus; a monitor pops one per observed output change. Pilot case needs TX_FRAME_CTRL_PILOT_EN.
module tb_tx_frame_ctrl;

    localparam int unsigned LEN_W = 12;

    typedef struct {
        logic [21:0] vec;
        int          len;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] payload_len;
    logic             abort;
    logic             sym_tick;
    logic             tx_en;
    logic [1:0]       src_sel;
    logic [3:0]       preamble_bits;
    logic [LEN_W-1:0] sym_idx;
    logic             busy;
    logic             frame_done;
    logic             len_err;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    bit   mon_en;
    bit   done_seen;

    tx_frame_ctrl #(
        .PREAMBLE_SYMS(32),
        .LEN_W        (LEN_W),
        .FLUSH_CLKS   (40),
        .GAP_CLKS     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .payload_len  (payload_len),
        .abort        (abort),
        .sym_tick     (sym_tick),
        .tx_en        (tx_en),
        .src_sel      (src_sel),
        .preamble_bits(preamble_bits),
        .sym_idx      (sym_idx),
        .busy         (busy),
        .frame_done   (frame_done),
        .len_err      (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] ev(input logic tx, input logic [1:0] src, input logic [3:0] pre,
                                       input int unsigned idx, input logic bsy, input logic dn,
                                       input logic le);
        return {tx, src, pre, 12'(idx), bsy, dn, le};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {tx_en, src_sel, preamble_bits, sym_idx, busy, frame_done, len_err};
    endfunction

    function automatic logic [21:0] idle_vec();
        return ev(1'b0, 2'b10, 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic push(input logic [21:0] v, input int len);
        exp_t e;
        e.vec = v;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_preamble();
        for (int k = 0; k < 32; k++) begin
            push(ev(1'b1, 2'b01, (k % 2 == 1) ? 4'b1010 : 4'b0000, k, 1'b1, 1'b0, 1'b0), 4);
        end
    endtask

    task automatic push_tail();
        push(ev(1'b1, 2'b10, 4'b0000, 0, 1'b1, 1'b0, 1'b0), 40);
        push(ev(1'b0, 2'b10, 4'b0000, 0, 1'b1, 1'b0, 1'b0), 16);
        push(ev(1'b0, 2'b10, 4'b0000, 0, 1'b0, 1'b1, 1'b0), 1);
        push(idle_vec(), 0);
    endtask

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int unsigned len, input logic ab);
        start       = 1'b1;
        payload_len = LEN_W'(len);
        abort       = ab;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic tick(input logic ab);
        cyc(3);
        sym_tick = 1'b1;
        abort    = ab;
        cyc(1);
        sym_tick = 1'b0;
        abort    = 1'b0;
    endtask

    // Segment-based monitor: a new segment starts whenever the output vector changes
    task automatic monitor_loop();
        logic [21:0] cur;
        logic [21:0] v;
        int          cnt;
        int          exp_len;
        bit          open;
        exp_t        e;
        int          seg;
        open    = 1'b0;
        cnt     = 0;
        exp_len = 0;
        cur     = '0;
        seg     = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                v = dut_vec();
                if (!open || v !== cur) begin
                    if (open && exp_len != 0) begin
                        n_vec++;
                        if (cnt != exp_len) begin
                            n_err++;
                            $display("FAIL seg%0d_len: held %0d clocks, expected %0d (vec %h)",
                                     seg, cnt, exp_len, cur);
                        end
                    end
                    seg++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL seg%0d_unexpected: got %h, expected no change", seg, v);
                        exp_len = 0;
                    end else begin
                        e = exp_q.pop_front();
                        if (e.vec !== v) begin
                            n_err++;
                            $display("FAIL seg%0d_vec: got %h expected %h", seg, v, e.vec);
                        end
                        exp_len = e.len;
                    end
                    cur  = v;
                    cnt  = 1;
                    open = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        mon_en      = 1'b0;
        done_seen   = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        payload_len = '0;
        abort       = 1'b0;
        sym_tick    = 1'b0;

        fork
            begin
                #2000000;
                n_err++;
                $display("FAIL watchdog: time limit expired");
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        join_none

        cyc(3);
        check("reset_values", dut_vec(), idle_vec());
        rst = 1'b0;
        cyc(2);

        push(idle_vec(), 0);
        fork
            monitor_loop();
        join_none
        mon_en = 1'b1;
        cyc(3);

        // Nominal frame, len 5; ticks during FLUSH and a start during GAP must be ignored
        push_preamble();
        for (int k = 0; k < 5; k++) push(ev(1'b1, 2'b00, 4'b0000, k, 1'b1, 1'b0, 1'b0), 4);
        push_tail();
        start_frame(5, 1'b0);
        for (int k = 0; k < 37; k++) tick(1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0);
        cyc(33);
        start_frame(5, 1'b0);
        cyc(20);

        // Zero length start is rejected
        push(ev(1'b0, 2'b10, 4'b0000, 0, 1'b0, 1'b0, 1'b1), 1);
        push(idle_vec(), 0);
        start_frame(0, 1'b0);
        cyc(6);

        // start together with abort in IDLE: no frame, no len_err
        start_frame(7, 1'b1);
        cyc(6);

        // Abort at payload symbol 2 of len 100
        push_preamble();
        push(ev(1'b1, 2'b00, 4'b0000, 0, 1'b1, 1'b0, 1'b0), 4);
        push(ev(1'b1, 2'b00, 4'b0000, 1, 1'b1, 1'b0, 1'b0), 4);
        push(ev(1'b1, 2'b00, 4'b0000, 2, 1'b1, 1'b0, 1'b0), 2);
        push_tail();
        start_frame(100, 1'b0);
        for (int k = 0; k < 34; k++) tick(1'b0);
        cyc(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(70);

        // Abort coincident with the final payload tick, len 3
        push_preamble();
        for (int k = 0; k < 3; k++) push(ev(1'b1, 2'b00, 4'b0000, k, 1'b1, 1'b0, 1'b0), 4);
        push_tail();
        start_frame(3, 1'b0);
        for (int k = 0; k < 34; k++) tick(1'b0);
        tick(1'b1);
        cyc(70);

`ifdef TX_FRAME_CTRL_PILOT_EN
        // Pilots after data symbols 16 and 32, none after 33: 35 payload-phase ticks
        push_preamble();
        for (int k = 0; k < 16; k++) push(ev(1'b1, 2'b00, 4'b0000, k, 1'b1, 1'b0, 1'b0), 4);
        push(ev(1'b1, 2'b11, 4'b0000, 16, 1'b1, 1'b0, 1'b0), 4);
        for (int k = 16; k < 32; k++) push(ev(1'b1, 2'b00, 4'b0000, k, 1'b1, 1'b0, 1'b0), 4);
        push(ev(1'b1, 2'b11, 4'b0000, 32, 1'b1, 1'b0, 1'b0), 4);
        push(ev(1'b1, 2'b00, 4'b0000, 32, 1'b1, 1'b0, 1'b0), 4);
        push_tail();
        start_frame(33, 1'b0);
        for (int k = 0; k < 32 + 35; k++) tick(1'b0);
        cyc(70);
`endif

        mon_en = 1'b0;
        cyc(1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected segments left, expected 0", exp_q.size());
        end

        // Reset asserted mid-PAYLOAD acts immediately and never produces frame_done
        start_frame(10, 1'b0);
        for (int k = 0; k < 34; k++) tick(1'b0);
        cyc(1);
        check("mid_payload_pre_reset", dut_vec(), ev(1'b1, 2'b00, 4'b0000, 2, 1'b1, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_values", dut_vec(), idle_vec());
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (frame_done) done_seen = 1'b1;
        end
        n_vec++;
        if (done_seen) begin
            n_err++;
            $display("FAIL reset_no_done: frame_done seen 1, expected 0");
        end
        check("post_reset_idle", dut_vec(), idle_vec());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
